// File: rtl/dns_bundle_if.sv
// -----------------------------------------------------------------------------
// dns_bundle_if
// Whole-packet DNS bundle handshake: one valid/ready pair qualifying the
// source/destination IPs, the UDP length and the flattened payload.
//
// Parameters:
//   PKT_WIDTH  payload vector width in bits (first payload byte in the MSBs)
//
// Signals:
//   dns_valid   bundle valid (producer -> consumer)
//   dns_ready   bundle accept (consumer -> producer)
//   udp_src_ip  32-bit source IP
//   udp_dst_ip  32-bit destination IP
//   udp_length  16-bit UDP length in bytes
//   dns_pkt     PKT_WIDTH-bit payload
//
// Modports:
//   master  drives the bundle (producer side)
//   slave   receives the bundle (consumer side)
// -----------------------------------------------------------------------------
interface dns_bundle_if #(
    parameter int PKT_WIDTH = 4096
);
    logic                 dns_valid;
    logic                 dns_ready;
    logic [31:0]          udp_src_ip;
    logic [31:0]          udp_dst_ip;
    logic [15:0]          udp_length;
    logic [PKT_WIDTH-1:0] dns_pkt;

    modport master (
        output dns_valid,
        input  dns_ready,
        output udp_src_ip,
        output udp_dst_ip,
        output udp_length,
        output dns_pkt
    );

    modport slave (
        input  dns_valid,
        output dns_ready,
        input  udp_src_ip,
        input  udp_dst_ip,
        input  udp_length,
        input  dns_pkt
    );
endinterface

// File: rtl/dns_rx_arbiter.sv
// -----------------------------------------------------------------------------
// dns_rx_arbiter
// Two-input round-robin arbiter and hold scheduler feeding one DNS consumer.
// A winning bundle is length-checked on accept; a legal bundle is held on
// registered outputs until the consumer takes it or the hold times out, an
// illegal one is discarded with a drop_len pulse.
//
// Parameters:
//   PKT_WIDTH  payload width in bits (multiple of 8)
//   MIN_LEN    minimum legal UDP length in bytes
//   TIMEOUT    HOLD cycles before a stalled bundle is dropped (0 = never)
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   s0, s1        input bundle ports (slave modport); readies are combinational
//   m             output bundle port (master modport); all fields registered
//   m_dns_port    input port index of the held bundle
//   drop_len      one-cycle pulse: accepted bundle failed the length check
//   drop_timeout  one-cycle pulse: held bundle dropped by the timeout
//
// Optional feature (macro DNS_RX_ARB_STATS_EN):
//   stat_fwd0, stat_fwd1  32-bit saturating delivery counts per input port
//   stat_drop             16-bit saturating count of length + timeout drops
// -----------------------------------------------------------------------------
module dns_rx_arbiter #(
    parameter int PKT_WIDTH = 4096,
    parameter int MIN_LEN   = 20,
    parameter int TIMEOUT   = 1024
) (
    input  logic         clk,
    input  logic         rst,
    dns_bundle_if.slave  s0,
    dns_bundle_if.slave  s1,
    dns_bundle_if.master m,
    output logic         m_dns_port,
    output logic         drop_len,
    output logic         drop_timeout
`ifdef DNS_RX_ARB_STATS_EN
    ,
    output logic [31:0]  stat_fwd0,
    output logic [31:0]  stat_fwd1,
    output logic [15:0]  stat_drop
`endif
);

    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_W = 16'(PKT_WIDTH / 8 + 8);
    localparam bit          TO_EN     = (TIMEOUT > 32'sd0);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_nx_s;
    logic [15:0]          cnt_r;
    logic [15:0]          cnt_nx_s;
    logic                 rr_last_r;
    logic                 drop_len_nx_s;
    logic                 drop_to_nx_s;

    logic                 win_valid_s;
    logic                 win_port_s;
    logic                 accept_s;
    logic [31:0]          sel_src_s;
    logic [31:0]          sel_dst_s;
    logic [15:0]          sel_len_s;
    logic [PKT_WIDTH-1:0] sel_pkt_s;

    // Unsigned bounds check of a UDP length against the legal range.
    function automatic logic len_ok(input logic [15:0] len);
        len_ok = (len >= MIN_LEN_W) && (len <= MAX_LEN_W);
    endfunction

    // Pick the winner: single valid port, or on a tie the port not granted last.
    always_comb begin
        win_valid_s = 1'b0;
        win_port_s  = 1'b0;
        if (s0.dns_valid && s1.dns_valid) begin
            win_valid_s = 1'b1;
            win_port_s  = ~rr_last_r;
        end else if (s0.dns_valid) begin
            win_valid_s = 1'b1;
            win_port_s  = 1'b0;
        end else if (s1.dns_valid) begin
            win_valid_s = 1'b1;
            win_port_s  = 1'b1;
        end else begin
            win_valid_s = 1'b0;
            win_port_s  = 1'b0;
        end
    end

    // Readies only in IDLE and out of reset; the winner's fields feed the capture.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && rst && win_valid_s;
        s0.dns_ready = accept_s && !win_port_s;
        s1.dns_ready = accept_s && win_port_s;
        if (win_port_s) begin
            sel_src_s = s1.udp_src_ip;
            sel_dst_s = s1.udp_dst_ip;
            sel_len_s = s1.udp_length;
            sel_pkt_s = s1.dns_pkt;
        end else begin
            sel_src_s = s0.udp_src_ip;
            sel_dst_s = s0.udp_dst_ip;
            sel_len_s = s0.udp_length;
            sel_pkt_s = s0.dns_pkt;
        end
    end

    // Next-state logic: accept/length check in IDLE, delivery or timeout in HOLD.
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r;
        drop_len_nx_s = 1'b0;
        drop_to_nx_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (len_ok(sel_len_s)) begin
                        state_nx_s = ST_HOLD;
                        cnt_nx_s   = 16'd0;
                    end else begin
                        drop_len_nx_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Ready has priority over a coincident timeout hit.
                if (m.dns_ready) begin
                    state_nx_s = ST_IDLE;
                end else if (TO_EN && (cnt_r == TO_LAST)) begin
                    state_nx_s   = ST_IDLE;
                    drop_to_nx_s = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r + 16'd1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = 16'd0;
            end
        endcase
    end

    // State, timeout counter, drop pulses and output valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 16'd0;
            drop_len     <= 1'b0;
            drop_timeout <= 1'b0;
            m.dns_valid  <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            drop_len     <= drop_len_nx_s;
            drop_timeout <= drop_to_nx_s;
            m.dns_valid  <= (state_nx_s == ST_HOLD);
        end
    end

    // Capture the winning bundle; fields persist after delivery or drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m.udp_src_ip <= 32'd0;
            m.udp_dst_ip <= 32'd0;
            m.udp_length <= 16'd0;
            m.dns_pkt    <= '0;
            m_dns_port   <= 1'b0;
            rr_last_r    <= 1'b1;
        end else if (accept_s) begin
            m.udp_src_ip <= sel_src_s;
            m.udp_dst_ip <= sel_dst_s;
            m.udp_length <= sel_len_s;
            m.dns_pkt    <= sel_pkt_s;
            m_dns_port   <= win_port_s;
            rr_last_r    <= win_port_s;
        end else begin
            rr_last_r    <= rr_last_r;
        end
    end

`ifdef DNS_RX_ARB_STATS_EN
    logic deliver_s;
    logic drop_evt_s;

    // Delivery and drop events that feed the statistics counters.
    always_comb begin
        deliver_s  = (state_r == ST_HOLD) && m.dns_ready;
        drop_evt_s = drop_len_nx_s || drop_to_nx_s;
    end

    // Saturating delivery/drop counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fwd0 <= 32'd0;
            stat_fwd1 <= 32'd0;
            stat_drop <= 16'd0;
        end else begin
            if (deliver_s && !m_dns_port && (stat_fwd0 != 32'hFFFF_FFFF)) begin
                stat_fwd0 <= stat_fwd0 + 32'd1;
            end
            if (deliver_s && m_dns_port && (stat_fwd1 != 32'hFFFF_FFFF)) begin
                stat_fwd1 <= stat_fwd1 + 32'd1;
            end
            if (drop_evt_s && (stat_drop != 16'hFFFF)) begin
                stat_drop <= stat_drop + 16'd1;
            end
        end
    end
`endif

endmodule
